// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and helpers for the data memory controller.
// Holds the FSM encoding, lane-mask builder and address-split helpers.
package mem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int MAX_BE = 16;

    function automatic int lane_bits(input int be_w);
        return (be_w > 1) ? $clog2(be_w) : 0;
    endfunction

    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [8*MAX_BE-1:0] lane_mask(
        input logic [MAX_BE-1:0] be
    );
        logic [8*MAX_BE-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_BE; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the load/store stage and data memory.
// master = core side, slave = memory controller.
interface data_memory_ctrl_if #(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 16,
    localparam int BE_W   = DATA_W / 8
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [BE_W-1:0]   req_be;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_byte_ram.sv
// Single-port word RAM with per-byte write enables.
// Read data is registered; reads and writes never share a cycle.
module mem_byte_ram
    import mem_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 256,
    localparam int BE_W   = DATA_W / 8,
    localparam int IW     = idx_bits(DEPTH)
) (
    input  logic              clk,
    input  logic [IW-1:0]     addr,
    input  logic [BE_W-1:0]   we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mask;

    assign mask = DATA_W'(lane_mask(MAX_BE'(we)));

    always_ff @(posedge clk) begin
        if (|we) begin
            mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: post-reset clear sequencer, address checks
// and a one-cycle registered response in front of mem_byte_ram.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_ctrl_if.slave  bus,
    output logic               init_done
);

    localparam int BE_W = DATA_W / 8;
    localparam int OFS  = lane_bits(BE_W);
    localparam int IW   = idx_bits(DEPTH);

    state_t            state_q, state_d;
    logic [IW-1:0]     cnt_q;
    logic              clr, ready;
    logic              acc, mis, oor, err;
    logic [IW-1:0]     widx;
    logic              rsp_v_q, err_q, rd_q;
    logic [IW-1:0]     ram_addr;
    logic [BE_W-1:0]   ram_we;
    logic [DATA_W-1:0] ram_wd;
    logic              ram_re;
    logic [DATA_W-1:0] ram_q;

    assign widx = bus.req_addr[OFS+IW-1:OFS];

    if (OFS > 0) begin : g_mis
        assign mis = |bus.req_addr[OFS-1:0];
    end else begin : g_nomis
        assign mis = 1'b0;
    end

    if (OFS + IW < ADDR_W) begin : g_oor
        assign oor = |bus.req_addr[ADDR_W-1:OFS+IW];
    end else begin : g_nooor
        assign oor = 1'b0;
    end

    assign err = mis | oor;
    assign acc = bus.req_valid & ready;

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        ready   = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                clr = 1'b1;
                if (cnt_q == IW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Clear and request traffic are exclusive by state, so one port suffices.
    always_comb begin
        ram_addr = widx;
        ram_we   = '0;
        ram_wd   = bus.req_wdata;
        ram_re   = 1'b0;
        if (clr) begin
            ram_addr = cnt_q;
            ram_we   = '1;
            ram_wd   = '0;
        end else if (acc && !err) begin
            ram_we = bus.req_we ? bus.req_be : '0;
            ram_re = !bus.req_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            rsp_v_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                cnt_q <= cnt_q + IW'(1);
            end
            rsp_v_q <= acc;
            err_q   <= acc & err;
            rd_q    <= acc & !bus.req_we & !err;
        end
    end

    mem_byte_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wd),
        .re    (ram_re),
        .rdata (ram_q)
    );

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_v_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rd_q ? ram_q : '0;
    assign init_done     = (state_q == ST_RUN);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: each accepted request pushes
// its expected response, which must appear exactly one cycle later.
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;

    data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    data_memory_ctrl #(
        .DATA_W (16),
        .ADDR_W (16),
        .DEPTH  (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model [256];
    int          checks = 0;
    int          errors = 0;
    int          n_rsp  = 0;
    logic [15:0] last_rdata;
    logic        last_err;

    function automatic logic addr_err(input logic [15:0] a);
        return a[0] | (|a[15:9]);
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid === 1'b1) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with nothing pending");
            end else begin
                e = exp_q.pop_front();
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
                if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                             bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                end
            end
        end else begin
            if (exp_q.size() != 0) begin
                errors++;
                void'(exp_q.pop_front());
                $display("FAIL missing_rsp: rsp_valid=%b, expected 1", bus.rsp_valid);
            end else if (bus.rsp_rdata !== 16'h0 || bus.rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL idle_rsp: rdata=%h err=%b, expected 0000/0",
                         bus.rsp_rdata, bus.rsp_err);
            end
        end
    endtask

    task automatic send(input logic we, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] wd);
        exp_t       e;
        logic [7:0] idx;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        if (bus.req_ready === 1'b1 && rst_n === 1'b1) begin
            idx     = addr[8:1];
            e.err   = addr_err(addr);
            e.rdata = 16'h0;
            if (!e.err) begin
                if (we) begin
                    for (int b = 0; b < 2; b++) begin
                        if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                    end
                end else begin
                    e.rdata = model[idx];
                end
            end
            exp_q.push_back(e);
        end
        step();
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        step();
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        foreach (model[i]) model[i] = 16'h0;
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (bus.req_ready !== 1'b0 || init_done !== 1'b0 ||
            bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 16'h0 ||
            bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%b done=%b valid=%b rdata=%h err=%b, expected all 0",
                     name, bus.req_ready, init_done, bus.rsp_valid,
                     bus.rsp_rdata, bus.rsp_err);
        end
    endtask

    task automatic check_init(input string name, input int n);
        checks++;
        if (n !== 256 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s: init took %0d cycles done=%b, expected 256 and 1",
                     name, n, init_done);
        end
    endtask

    task automatic check_read(input string name, input logic [15:0] exp_d,
                              input logic exp_e);
        checks++;
        if (last_rdata !== exp_d || last_err !== exp_e) begin
            errors++;
            $display("FAIL %s: got %h err=%b, expected %h err=%b",
                     name, last_rdata, last_err, exp_d, exp_e);
        end
    endtask

    task automatic test_reset();
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_be    = 2'b00;
        bus.req_addr  = 16'h00FE;
        bus.req_wdata = 16'h0;
        rst_n = 1'b0;
        step();
        step();
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        wait_init(n);
        check_init("reset_init_len", n);
        send(1'b0, 2'b00, 16'h00FE, 16'h0);
        check_read("read_after_init", 16'h0000, 1'b0);
    endtask

    task automatic test_write_read();
        send(1'b1, 2'b11, 16'h0010, 16'hBEEF);
        send(1'b0, 2'b00, 16'h0010, 16'h0);
        check_read("write_read", 16'hBEEF, 1'b0);
        idle();
    endtask

    task automatic test_byte_enable();
        send(1'b1, 2'b01, 16'h0010, 16'h1234);
        send(1'b0, 2'b00, 16'h0010, 16'h0);
        check_read("be_low", 16'hBE34, 1'b0);
        send(1'b1, 2'b10, 16'h0030, 16'hA1B2);
        send(1'b0, 2'b11, 16'h0030, 16'hFFFF);
        check_read("be_high", 16'hA100, 1'b0);
        send(1'b1, 2'b00, 16'h0030, 16'h5555);
        send(1'b0, 2'b00, 16'h0030, 16'h0);
        check_read("be_zero_noop", 16'hA100, 1'b0);
        idle();
    endtask

    task automatic test_errors();
        send(1'b0, 2'b00, 16'h0011, 16'h0);
        check_read("misaligned_rd", 16'h0000, 1'b1);
        send(1'b0, 2'b00, 16'h0200, 16'h0);
        check_read("oor_rd", 16'h0000, 1'b1);
        send(1'b1, 2'b11, 16'h0011, 16'hFFFF);
        check_read("misaligned_wr", 16'h0000, 1'b1);
        send(1'b1, 2'b11, 16'h0210, 16'hDEAD);
        check_read("oor_wr", 16'h0000, 1'b1);
        send(1'b0, 2'b00, 16'h0010, 16'h0);
        check_read("no_corruption", 16'hBE34, 1'b0);
        idle();
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = n_rsp;
        send(1'b1, 2'b11, 16'h0020, 16'hA5A5);
        send(1'b0, 2'b00, 16'h0020, 16'h0);
        check_read("b2b_rd1", 16'hA5A5, 1'b0);
        send(1'b1, 2'b10, 16'h0020, 16'h5A5A);
        send(1'b0, 2'b00, 16'h0020, 16'h0);
        check_read("b2b_rd2", 16'h5AA5, 1'b0);
        idle();
        checks++;
        if (n_rsp - n0 != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses, expected 4", n_rsp - n0);
        end
    endtask

    task automatic test_reset_init();
        int n;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0010;
        repeat (100) step();
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_ready: ready=%b during clear, expected 0", bus.req_ready);
        end
        rst_n = 1'b0;
        step();
        check_outputs_zero("reset_in_init");
        rst_n = 1'b1;
        wait_init(n);
        check_init("reinit_len", n);
        idle();
    endtask

    task automatic test_reset_run();
        int n;
        send(1'b1, 2'b11, 16'h0010, 16'h7777);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0010;
        rst_n = 1'b0;
        exp_q.delete();
        step();
        check_outputs_zero("reset_in_run");
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        wait_init(n);
        check_init("run_reinit_len", n);
        send(1'b0, 2'b00, 16'h0010, 16'h0);
        check_read("cleared_after_reset", 16'h0000, 1'b0);
        idle();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_be    = 2'b00;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;
        last_rdata    = 16'h0;
        last_err      = 1'b0;
        foreach (model[i]) model[i] = 16'h0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_reset_init();
        test_reset_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
